score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Game-flow and score producer feeding the score renderer.
- Counts goals for player and enemy and sequences wait-start, serve, play and game-over.
- Gates ball motion and chooses the serve direction.
- Emits 3x5 digit glyphs (score_t) for both players, ready for scaled drawing at P_SCORE_X/Y and E_SCORE_X/Y.

Parameters:
- MAX_SCORE, 5, winning score (1..9).
- MAX_SCORE_W, 4, score counter width.
- SERVE_FRAMES, 60, frame ticks between goal/start and ball release (>=1).
- FLASH_FRAMES, 16, frame ticks per visibility toggle in game over (>=1).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- frame_tick_i  in  1  one-cycle pulse per video frame
- start_i  in  1  start button level, already debounced
- p_goal_i  in  1  one-cycle pulse: player scored (ball left the enemy side)
- e_goal_i  in  1  one-cycle pulse: enemy scored
- p_score_o  out  MAX_SCORE_W  player score
- e_score_o  out  MAX_SCORE_W  enemy score
- p_glyph_o  out  15 (score_t)  player digit bitmap
- e_glyph_o  out  15 (score_t)  enemy digit bitmap
- ball_en_o  out  1  ball may move
- serve_dir_o  out  1  1 = serve toward player, 0 = toward enemy
- game_over_o  out  1  a side reached MAX_SCORE
- winner_o  out  1  1 = player won; valid while game_over_o is 1

Behaviour:
- Clock and reset:
  - Single clock clk_i; rst_i is synchronous and active-high.
  - Reset values: scores 0, state ST_WAIT_START, ball_en_o 0, serve_dir_o 0, game_over_o 0, winner_o 0, visibility 1, both glyphs ZERO.
  - Reset mid-game takes effect on the next edge, with no residual counts.
- Start edge detection:
  - start_rise = start_i & ~start_q.
  - start_q resets to 1, so a button held through reset does not start a game.
- States, in keeper_state_e (2-bit):
  - ST_WAIT_START:
    - ball_en_o 0; goals ignored.
    - start_rise: scores cleared, serve counter loaded with SERVE_FRAMES, serve_dir_o 0, go to ST_SERVE.
  - ST_SERVE:
    - ball_en_o 0; goals and start ignored.
    - Each frame_tick_i decrements the counter.
    - A tick with counter==1 moves to ST_PLAY on the next edge, so release comes exactly SERVE_FRAMES ticks after entry.
  - ST_PLAY:
    - ball_en_o 1.
    - p_goal_i alone: p_score+1, serve_dir_o 0 (toward the conceding enemy).
    - e_goal_i alone: e_score+1, serve_dir_o 1.
    - If the new score equals MAX_SCORE: ST_GAME_OVER, game_over_o 1, winner_o set to the scorer. Otherwise ST_SERVE with the counter reloaded.
    - p_goal_i and e_goal_i in the same cycle: illegal, both ignored, stay in ST_PLAY.
    - ball_en_o drops the cycle after the goal pulse.
  - ST_GAME_OVER:
    - ball_en_o 0; goals ignored.
    - Visibility toggles every FLASH_FRAMES ticks.
    - start_rise: scores cleared, game_over_o 0, visibility 1, counter reloaded, go to ST_SERVE.
    - winner_o holds its value until the next game over.
- Arithmetic:
  - Scores saturate at MAX_SCORE and never wrap.
  - No increment happens outside ST_PLAY.
- Glyphs:
  - Registered; they update one cycle after the score register, i.e. two edges after the goal pulse.
  - Value is score_e of the digit when visibility is 1, all-zero when visibility is 0.
  - Scores above 9 map to all-zero (unreachable with legal parameters).

Decomposition:
- score_pkg gains:
  - keeper_state_e {ST_WAIT_START, ST_SERVE, ST_PLAY, ST_GAME_OVER}
  - SERVE_FRAMES and FLASH_FRAMES defaults
- The existing 1-bit state_e is not reused for this block.
- Sub-module score_glyph_rom (combinational): digit in MAX_SCORE_W, score_t out via the score_e table. Instantiated twice, outputs registered in score_keeper.

Test Plan:
- Reset with start_i held 1, then release and press -> no start until the new rising edge; after the press, ST_SERVE, ball_en_o 1 exactly 60 frame ticks later, glyphs ZERO.
- In play, a p_goal_i pulse -> p_score_o 1 next edge, p_glyph_o ONE one edge later, serve_dir_o 0, ball_en_o 0 for 60 ticks, then 1.
- p_goal_i and e_goal_i in the same cycle -> scores unchanged, ball_en_o stays 1.
- Enemy scores 5 -> game_over_o 1, winner_o 0; later goal pulses leave e_score_o at 5; e_glyph_o alternates FIVE / all-zero every 16 ticks.
- Game over, then a start press -> scores 0, game_over_o 0, glyphs ZERO visible, serve sequence restarts.
- rst_i asserted mid-serve with the counter at 30 -> all outputs at reset values on the next edge; a new start gives a full 60-tick delay.

Source files
------------

// File: rtl/score_pkg.sv
// Shared score types: 3x5 digit glyphs, game-flow states and screen placement.
package score_pkg;

  localparam int unsigned GLYPH_W   = 15;
  localparam int unsigned P_SCORE_X = 240;
  localparam int unsigned P_SCORE_Y = 16;
  localparam int unsigned E_SCORE_X = 368;
  localparam int unsigned E_SCORE_Y = 16;

  localparam int unsigned DEFAULT_MAX_SCORE    = 5;
  localparam int unsigned DEFAULT_MAX_SCORE_W  = 4;
  localparam int unsigned DEFAULT_SERVE_FRAMES = 60;
  localparam int unsigned DEFAULT_FLASH_FRAMES = 16;

  // One glyph row per field, row0 on top, MSB of a row is the leftmost pixel.
  typedef struct packed {
    logic [2:0] row0;
    logic [2:0] row1;
    logic [2:0] row2;
    logic [2:0] row3;
    logic [2:0] row4;
  } score_t;

  typedef enum logic [GLYPH_W-1:0] {
    ZERO  = 15'b111_101_101_101_111,
    ONE   = 15'b010_110_010_010_111,
    TWO   = 15'b111_001_111_100_111,
    THREE = 15'b111_001_111_001_111,
    FOUR  = 15'b101_101_111_001_001,
    FIVE  = 15'b111_100_111_001_111,
    SIX   = 15'b111_100_111_101_111,
    SEVEN = 15'b111_001_001_001_001,
    EIGHT = 15'b111_101_111_101_111,
    NINE  = 15'b111_101_111_001_111
  } score_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    ST_WAIT_START,
    ST_SERVE,
    ST_PLAY,
    ST_GAME_OVER
  } keeper_state_e;

endpackage

// File: rtl/score_keeper_if.sv
// Game-event inputs and score/flow outputs of the score keeper.
interface score_keeper_if #(
  parameter int unsigned MAX_SCORE_W = score_pkg::DEFAULT_MAX_SCORE_W
);

  logic                   frame_tick_i;
  logic                   start_i;
  logic                   p_goal_i;
  logic                   e_goal_i;
  logic [MAX_SCORE_W-1:0] p_score_o;
  logic [MAX_SCORE_W-1:0] e_score_o;
  score_pkg::score_t      p_glyph_o;
  score_pkg::score_t      e_glyph_o;
  logic                   ball_en_o;
  logic                   serve_dir_o;
  logic                   game_over_o;
  logic                   winner_o;

  modport master (
    output frame_tick_i, start_i, p_goal_i, e_goal_i,
    input  p_score_o, e_score_o, p_glyph_o, e_glyph_o,
    input  ball_en_o, serve_dir_o, game_over_o, winner_o
  );

  modport slave (
    input  frame_tick_i, start_i, p_goal_i, e_goal_i,
    output p_score_o, e_score_o, p_glyph_o, e_glyph_o,
    output ball_en_o, serve_dir_o, game_over_o, winner_o
  );

endinterface

// File: rtl/score_glyph_rom.sv
// Digit to 3x5 glyph lookup; out-of-range digits render blank.
module score_glyph_rom
  import score_pkg::*;
#(
  parameter int unsigned MAX_SCORE_W = DEFAULT_MAX_SCORE_W
) (
  input  logic [MAX_SCORE_W-1:0] digit,
  output score_t                 glyph_c
);

  always_comb begin
    glyph_c = '0;
    case (32'(digit))
      0:       glyph_c = score_t'(ZERO);
      1:       glyph_c = score_t'(ONE);
      2:       glyph_c = score_t'(TWO);
      3:       glyph_c = score_t'(THREE);
      4:       glyph_c = score_t'(FOUR);
      5:       glyph_c = score_t'(FIVE);
      6:       glyph_c = score_t'(SIX);
      7:       glyph_c = score_t'(SEVEN);
      8:       glyph_c = score_t'(EIGHT);
      9:       glyph_c = score_t'(NINE);
      default: glyph_c = '0;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Game-flow sequencer and score counters feeding the score renderer.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned MAX_SCORE    = DEFAULT_MAX_SCORE,
  parameter int unsigned MAX_SCORE_W  = DEFAULT_MAX_SCORE_W,
  parameter int unsigned SERVE_FRAMES = DEFAULT_SERVE_FRAMES,
  parameter int unsigned FLASH_FRAMES = DEFAULT_FLASH_FRAMES
) (
  input logic           clk_i,
  input logic           rst_i,
  score_keeper_if.slave bus
);

  localparam int unsigned SERVE_W = $clog2(SERVE_FRAMES + 1);
  localparam int unsigned FLASH_W = $clog2(FLASH_FRAMES + 1);

  localparam logic [MAX_SCORE_W-1:0] SCORE_MAX  = MAX_SCORE_W'(MAX_SCORE);
  localparam logic [MAX_SCORE_W-1:0] SCORE_LAST = MAX_SCORE_W'(MAX_SCORE - 1);
  localparam logic [SERVE_W-1:0]     SERVE_LOAD = SERVE_W'(SERVE_FRAMES);
  localparam logic [FLASH_W-1:0]     FLASH_LOAD = FLASH_W'(FLASH_FRAMES);

  keeper_state_e          state;
  logic [MAX_SCORE_W-1:0] p_score;
  logic [MAX_SCORE_W-1:0] e_score;
  logic [SERVE_W-1:0]     serve_cnt;
  logic [FLASH_W-1:0]     flash_cnt;
  logic                   visible;
  logic                   start_q;
  logic                   ball_en;
  logic                   serve_dir;
  logic                   game_over;
  logic                   winner;
  score_t                 p_glyph;
  score_t                 e_glyph;

  logic   start_rise_c;
  logic   goal_c;
  logic   win_c;
  score_t p_glyph_c;
  score_t e_glyph_c;

  assign start_rise_c = bus.start_i & ~start_q;
  // Exactly one goal pulse counts; a simultaneous pair is treated as noise.
  assign goal_c = bus.p_goal_i ^ bus.e_goal_i;
  assign win_c  = bus.p_goal_i ? (p_score == SCORE_LAST) : (e_score == SCORE_LAST);

  score_glyph_rom #(.MAX_SCORE_W(MAX_SCORE_W)) u_p_rom (
    .digit   (p_score),
    .glyph_c (p_glyph_c)
  );

  score_glyph_rom #(.MAX_SCORE_W(MAX_SCORE_W)) u_e_rom (
    .digit   (e_score),
    .glyph_c (e_glyph_c)
  );

  // Flow FSM with score, serve and flash counters; all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_WAIT_START;
      p_score   <= '0;
      e_score   <= '0;
      serve_cnt <= '0;
      flash_cnt <= '0;
      visible   <= 1'b1;
      start_q   <= 1'b1;
      ball_en   <= 1'b0;
      serve_dir <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      p_glyph   <= score_t'(ZERO);
      e_glyph   <= score_t'(ZERO);
    end else begin
      start_q <= bus.start_i;
      p_glyph <= visible ? p_glyph_c : '0;
      e_glyph <= visible ? e_glyph_c : '0;

      case (state)
        ST_WAIT_START: begin
          ball_en <= 1'b0;
          if (start_rise_c) begin
            p_score   <= '0;
            e_score   <= '0;
            serve_cnt <= SERVE_LOAD;
            serve_dir <= 1'b0;
            state     <= ST_SERVE;
          end
        end

        ST_SERVE: begin
          if (bus.frame_tick_i) begin
            if (serve_cnt == SERVE_W'(1)) begin
              ball_en <= 1'b1;
              state   <= ST_PLAY;
            end else begin
              serve_cnt <= serve_cnt - SERVE_W'(1);
            end
          end
        end

        ST_PLAY: begin
          if (goal_c) begin
            ball_en   <= 1'b0;
            serve_dir <= bus.e_goal_i;
            if (bus.p_goal_i && (p_score < SCORE_MAX)) begin
              p_score <= p_score + MAX_SCORE_W'(1);
            end
            if (bus.e_goal_i && (e_score < SCORE_MAX)) begin
              e_score <= e_score + MAX_SCORE_W'(1);
            end
            if (win_c) begin
              game_over <= 1'b1;
              winner    <= bus.p_goal_i;
              flash_cnt <= FLASH_LOAD;
              state     <= ST_GAME_OVER;
            end else begin
              serve_cnt <= SERVE_LOAD;
              state     <= ST_SERVE;
            end
          end
        end

        ST_GAME_OVER: begin
          ball_en <= 1'b0;
          if (start_rise_c) begin
            p_score   <= '0;
            e_score   <= '0;
            game_over <= 1'b0;
            visible   <= 1'b1;
            serve_cnt <= SERVE_LOAD;
            state     <= ST_SERVE;
          end else if (bus.frame_tick_i) begin
            if (flash_cnt == FLASH_W'(1)) begin
              visible   <= ~visible;
              flash_cnt <= FLASH_LOAD;
            end else begin
              flash_cnt <= flash_cnt - FLASH_W'(1);
            end
          end
        end

        default: state <= ST_WAIT_START;
      endcase
    end
  end

  assign bus.p_score_o   = p_score;
  assign bus.e_score_o   = e_score;
  assign bus.p_glyph_o   = p_glyph;
  assign bus.e_glyph_o   = e_glyph;
  assign bus.ball_en_o   = ball_en;
  assign bus.serve_dir_o = serve_dir;
  assign bus.game_over_o = game_over;
  assign bus.winner_o    = winner;

endmodule

// File: tb/tb_score_keeper.sv
// Directed and random game sequences checked against an event-level model.
module tb_score_keeper;
  import score_pkg::*;

  localparam int MAX   = 5;
  localparam int SERVE = 60;
  localparam int FLASH = 16;

  localparam int PH_WAIT  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_OVER  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_keeper_if #(.MAX_SCORE_W(4)) bus ();

  score_keeper #(
    .MAX_SCORE    (MAX),
    .MAX_SCORE_W  (4),
    .SERVE_FRAMES (SERVE),
    .FLASH_FRAMES (FLASH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  bit st_lvl = 1'b1;

  // Model: game phase plus tick counts since entering serve / game over.
  int          m_phase, m_p, m_e, m_serve_ticks, m_flash_ticks;
  bit          m_dir, m_over, m_win, m_start_prev;
  logic [14:0] m_pgl, m_egl;
  logic [14:0] gtab [10];

  function automatic logic [14:0] glyph_of(input int d);
    if (d >= 0 && d <= 9) return gtab[d];
    return 15'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit tk, input bit st, input bit pg, input bit eg);
    bit vis, rise;
    int sc;
    if (r) begin
      m_phase = PH_WAIT; m_p = 0; m_e = 0; m_dir = 0; m_over = 0; m_win = 0;
      m_start_prev = 1; m_serve_ticks = 0; m_flash_ticks = 0;
      m_pgl = glyph_of(0); m_egl = glyph_of(0);
      return;
    end
    vis   = (m_phase != PH_OVER) || (((m_flash_ticks / FLASH) % 2) == 0);
    m_pgl = vis ? glyph_of(m_p) : 15'd0;
    m_egl = vis ? glyph_of(m_e) : 15'd0;
    rise  = st && !m_start_prev;
    m_start_prev = st;
    case (m_phase)
      PH_WAIT: if (rise) begin
        m_p = 0; m_e = 0; m_dir = 0; m_serve_ticks = 0; m_phase = PH_SERVE;
      end
      PH_SERVE: if (tk) begin
        m_serve_ticks++;
        if (m_serve_ticks == SERVE) m_phase = PH_PLAY;
      end
      PH_PLAY: if (pg != eg) begin
        if (pg) begin m_p = (m_p + 1 > MAX) ? MAX : m_p + 1; sc = m_p; m_dir = 0; end
        else    begin m_e = (m_e + 1 > MAX) ? MAX : m_e + 1; sc = m_e; m_dir = 1; end
        if (sc == MAX) begin
          m_phase = PH_OVER; m_over = 1; m_win = pg; m_flash_ticks = 0;
        end else begin
          m_phase = PH_SERVE; m_serve_ticks = 0;
        end
      end
      default: begin
        if (rise) begin
          m_p = 0; m_e = 0; m_over = 0; m_serve_ticks = 0; m_phase = PH_SERVE;
        end else if (tk) begin
          m_flash_ticks++;
        end
      end
    endcase
  endtask

  task automatic step(input bit r, input bit tk, input bit pg, input bit eg);
    @(negedge clk);
    rst              = r;
    bus.frame_tick_i = tk;
    bus.start_i      = st_lvl;
    bus.p_goal_i     = pg;
    bus.e_goal_i     = eg;
    @(posedge clk);
    model_step(r, tk, st_lvl, pg, eg);
    #1;
    chk("p_score",   32'(bus.p_score_o),   32'(m_p));
    chk("e_score",   32'(bus.e_score_o),   32'(m_e));
    chk("p_glyph",   32'(bus.p_glyph_o),   32'(m_pgl));
    chk("e_glyph",   32'(bus.e_glyph_o),   32'(m_egl));
    chk("ball_en",   32'(bus.ball_en_o),   32'(m_phase == PH_PLAY));
    chk("serve_dir", 32'(bus.serve_dir_o), 32'(m_dir));
    chk("game_over", 32'(bus.game_over_o), 32'(m_over));
    chk("winner",    32'(bus.winner_o),    32'(m_win));
  endtask

  task automatic press_start();
    st_lvl = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    st_lvl = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to_play();
    for (int i = 0; i < 400 && m_phase != PH_PLAY; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reached_play", 32'(m_phase), 32'(PH_PLAY));
  endtask

  initial begin
    gtab[0] = ZERO;  gtab[1] = ONE;   gtab[2] = TWO;   gtab[3] = THREE; gtab[4] = FOUR;
    gtab[5] = FIVE;  gtab[6] = SIX;   gtab[7] = SEVEN; gtab[8] = EIGHT; gtab[9] = NINE;
    bus.frame_tick_i = 1'b0; bus.start_i = 1'b1; bus.p_goal_i = 1'b0; bus.e_goal_i = 1'b0;

    // Reset with start held, then keep holding: no game may begin.
    st_lvl = 1'b1;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (70) step(1'b0, 1'b1, 1'b0, 1'b0);

    // Fresh press: exactly SERVE ticks to release.
    press_start();
    run_to_play();

    // Player goal, serve delay, then an illegal double goal.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    run_to_play();
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Enemy wins, goals afterwards are ignored, glyph flashes.
    for (int g = 0; g < MAX; g++) begin
      run_to_play();
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, (i % 7) == 0, (i % 5) == 0);

    // Restart from game over, then reset mid-serve at 30 ticks.
    press_start();
    for (int i = 0; i < 100 && m_serve_ticks < 30; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    press_start();
    run_to_play();

    // Random play with occasional start toggles and rare resets.
    for (int i = 0; i < 6000; i++) begin
      int g;
      if ($urandom_range(0, 59) == 0) st_lvl = ~st_lvl;
      g = int'($urandom_range(0, 29));
      step($urandom_range(0, 1999) == 0, $urandom_range(0, 2) == 0, g == 0 || g == 2, g == 1 || g == 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
